// File: rtl/bus_io_pkg.sv
// Shared definitions for the memory-mapped switch/display I/O port:
// register offsets, STATUS/CTRL bit positions and the debounce state type.
package bus_io_pkg;

    localparam logic [1:0] SW_DATA_OFF = 2'd0;
    localparam logic [1:0] STATUS_OFF  = 2'd1;
    localparam logic [1:0] DISP_OFF    = 2'd2;
    localparam logic [1:0] CTRL_OFF    = 2'd3;

    localparam int STATUS_CHG_BIT = 0;
    localparam int CTRL_IEN_BIT   = 0;

    typedef enum logic {
        DB_IDLE  = 1'b0,
        DB_COUNT = 1'b1
    } db_state_e;

endpackage

// File: rtl/bus_io_port_if.sv
// Bus-side view of the I/O port: address, chip select and direction from the
// sequencer/MAR, plus the window-hit indication returned to the RAM.
interface bus_io_port_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] addr;
    logic              CS;
    logic              R_NW;
    logic              hit;

    modport master (output addr, output CS, output R_NW, input hit);
    modport slave  (input addr, input CS, input R_NW, output hit);
endinterface

// File: rtl/switch_debounce.sv
// Two-flop synchroniser and counting debouncer for the board switches;
// emits the accepted value and a single-cycle accept strobe.
module switch_debounce
    import bus_io_pkg::*;
#(
    parameter int W         = 8,
    parameter int DB_CYCLES = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] sw_i,
    output logic [W-1:0] sw_stable_o,
    output logic         accept_o
);

    localparam int            CW      = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

    logic [W-1:0]  sync1_q, sync2_q;
    logic [W-1:0]  stable_q, stable_d;
    logic [W-1:0]  cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    db_state_e     state_q, state_d;
    logic          accept_s;

    // State register, synchroniser and debounce bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= {W{1'b0}};
            sync2_q  <= {W{1'b0}};
            stable_q <= {W{1'b0}};
            cand_q   <= {W{1'b0}};
            cnt_q    <= {CW{1'b0}};
            state_q  <= DB_IDLE;
        end else begin
            sync1_q  <= sw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
        end
    end

    // Next-state logic; the edge leaving IDLE already counts as the first stable cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        stable_d = stable_q;
        accept_s = 1'b0;
        case (state_q)
            DB_IDLE: begin
                if (sync2_q != stable_q) begin
                    state_d = DB_COUNT;
                    cnt_d   = CNT_ONE;
                    cand_d  = sync2_q;
                end else begin
                    cnt_d = {CW{1'b0}};
                end
            end
            DB_COUNT: begin
                if (sync2_q == stable_q) begin
                    state_d = DB_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else if (sync2_q != cand_q) begin
                    cand_d = sync2_q;
                    cnt_d  = {CW{1'b0}};
                end else if (cnt_q == CNT_MAX) begin
                    accept_s = 1'b1;
                    stable_d = sync2_q;
                    cnt_d    = {CW{1'b0}};
                    state_d  = DB_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = DB_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    assign sw_stable_o = stable_q;
    assign accept_o    = accept_s;

endmodule

// File: rtl/bus_io_port.sv
// Memory-mapped responder for a 4-register window: switch data, change status,
// display latch and interrupt control, driving sysbus only on a read hit.
module bus_io_port
    import bus_io_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int OP_W      = 3,
    parameter int BASE      = 28,
    parameter int DB_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    bus_io_port_if.slave      bus,
    inout  wire  [WORD_W-1:0] sysbus,
    input  logic [WORD_W-1:0] switches,
    output logic [WORD_W-1:0] disp,
    output logic              irq
);

    localparam int                ADDR_W = WORD_W - OP_W;
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

    logic [WORD_W-1:0] disp_q, disp_d;
    logic              ien_q, ien_d;
    logic              chg_q, chg_d;
    logic              irq_q;
    logic [WORD_W-1:0] rdata_s;
    logic [WORD_W-1:0] sw_stable_s;
    logic              accept_s;
    logic              hit_s, rd_s, wr_s, status_clr_s;
    logic [1:0]        off_s;

    switch_debounce #(
        .W         (WORD_W),
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clock       (clock),
        .reset       (reset),
        .sw_i        (switches),
        .sw_stable_o (sw_stable_s),
        .accept_o    (accept_s)
    );

    assign hit_s   = bus.CS && (bus.addr[ADDR_W-1:2] == BASE_A[ADDR_W-1:2]);
    assign off_s   = bus.addr[1:0];
    assign rd_s    = hit_s && bus.R_NW;
    assign wr_s    = hit_s && !bus.R_NW;
    assign bus.hit = hit_s;

    // A STATUS read clears chg at its closing edge; a STATUS write clears it only with bit0 set.
    assign status_clr_s = hit_s && (off_s == STATUS_OFF) &&
                          (bus.R_NW || sysbus[STATUS_CHG_BIT]);

    // Read data mux, zero-extending the single-bit registers.
    always_comb begin
        rdata_s = {WORD_W{1'b0}};
        case (off_s)
            SW_DATA_OFF: rdata_s = sw_stable_s;
            STATUS_OFF:  rdata_s[STATUS_CHG_BIT] = chg_q;
            DISP_OFF:    rdata_s = disp_q;
            CTRL_OFF:    rdata_s[CTRL_IEN_BIT] = ien_q;
            default:     rdata_s = {WORD_W{1'b0}};
        endcase
    end

    assign sysbus = rd_s ? rdata_s : {WORD_W{1'bz}};

    // Register next-state: bus writes and the change flag, where a new acceptance beats a clear.
    always_comb begin
        disp_d = disp_q;
        ien_d  = ien_q;
        chg_d  = chg_q;
        if (wr_s) begin
            case (off_s)
                DISP_OFF: disp_d = sysbus;
                CTRL_OFF: ien_d  = sysbus[CTRL_IEN_BIT];
                default:  disp_d = disp_q;
            endcase
        end else begin
            disp_d = disp_q;
        end
        if (accept_s) begin
            chg_d = 1'b1;
        end else if (status_clr_s) begin
            chg_d = 1'b0;
        end else begin
            chg_d = chg_q;
        end
    end

    // Register state; reset discards any write presented in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            disp_q <= {WORD_W{1'b0}};
            ien_q  <= 1'b0;
            chg_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            disp_q <= disp_d;
            ien_q  <= ien_d;
            chg_q  <= chg_d;
            irq_q  <= chg_d && ien_d;
        end
    end

    assign disp = disp_q;
    assign irq  = irq_q;

endmodule

// File: tb/tb_bus_io_port.sv
// Directed plus randomized bench for bus_io_port, checked against a behavioural
// model of the register window and a run-length view of the switch debouncer.
module tb_bus_io_port;

    localparam int DB = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] switches;
    logic [7:0] disp;
    logic       irq;
    logic       tb_oe;
    logic [7:0] tb_dat;
    wire  [7:0] sysbus;

    assign sysbus = tb_oe ? tb_dat : 8'hzz;

    bus_io_port_if #(.ADDR_W(5)) bus ();

    bus_io_port #(
        .WORD_W    (8),
        .OP_W      (3),
        .BASE      (28),
        .DB_CYCLES (DB)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .sysbus   (sysbus),
        .switches (switches),
        .disp     (disp),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] m_disp, m_stable, m_s1, m_s2, m_cand;
    logic       m_chg, m_ien, m_irq;
    int         m_run   = 0;
    logic       m_fresh = 1'b1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    function automatic logic m_hit(input logic cs, input logic [4:0] a);
        return cs && (a[4:2] == 3'd7);
    endfunction

    function automatic logic [7:0] m_read(input logic [1:0] off);
        case (off)
            2'd0:    return m_stable;
            2'd1:    return {7'b0, m_chg};
            2'd2:    return m_disp;
            default: return {7'b0, m_ien};
        endcase
    endfunction

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_edge();
        logic acc;
        logic h;
        logic [1:0] off;
        if (reset) begin
            m_disp = 8'h00; m_stable = 8'h00; m_s1 = 8'h00; m_s2 = 8'h00;
            m_cand = 8'h00; m_chg = 1'b0; m_ien = 1'b0; m_irq = 1'b0;
            m_run = 0; m_fresh = 1'b1;
            return;
        end
        h   = m_hit(bus.CS, bus.addr);
        off = bus.addr[1:0];
        acc = 1'b0;
        // A new value needs DB identical samples; one that replaced another pending value needs DB+1.
        if (m_s2 == m_stable) begin
            m_run = 0;
        end else if (m_run > 0 && m_s2 == m_cand) begin
            m_run++;
        end else begin
            m_fresh = (m_run == 0);
            m_cand  = m_s2;
            m_run   = 1;
        end
        if (m_run > 0 && m_run == (m_fresh ? DB : DB + 1)) begin
            acc = 1'b1; m_stable = m_cand; m_run = 0;
        end
        if (acc) m_chg = 1'b1;
        else if (h && off == 2'd1 && (bus.R_NW || tb_dat[0])) m_chg = 1'b0;
        if (h && !bus.R_NW && off == 2'd2) m_disp = tb_dat;
        if (h && !bus.R_NW && off == 2'd3) m_ien = tb_dat[0];
        m_irq = m_chg && m_ien;
        m_s2 = m_s1;
        m_s1 = switches;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        chk("disp", disp, m_disp);
        chk("irq", {7'b0, irq}, {7'b0, m_irq});
    endtask

    task automatic set_bus(input logic cs, input logic rnw, input logic [4:0] a, input logic [7:0] d);
        bus.CS   = cs;
        bus.R_NW = rnw;
        bus.addr = a;
        tb_dat   = d;
        tb_oe    = !(cs && rnw && a[4:2] == 3'd7);
    endtask

    task automatic bus_idle();
        set_bus(1'b0, 1'b1, 5'd0, 8'h00);
    endtask

    // Non-destructive read: check data and hit, then drop CS before the edge.
    task automatic peek(input string tag, input logic [4:0] a, input logic [7:0] exp_c);
        set_bus(1'b1, 1'b1, a, 8'h00);
        #1;
        chk(tag, sysbus, m_read(a[1:0]));
        chk({tag, "_const"}, sysbus, exp_c);
        chk({tag, "_hit"}, {7'b0, bus.hit}, 8'h01);
        bus_idle();
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        set_bus(1'b1, 1'b0, a, d);
        tick();
        bus_idle();
    endtask

    initial begin
        logic [4:0] a;
        logic [7:0] exp_v;
        int hold;
        int op;

        switches = 8'h00;
        reset    = 1'b1;
        bus_idle();
        tick();
        tick();
        reset = 1'b0;

        // Reset values and CS=0 leaves the bus alone
        for (int i = 0; i < 4; i++) begin
            a = 5'd28 + 5'(i);
            peek("rst_reg", a, 8'h00);
        end
        set_bus(1'b0, 1'b1, 5'd30, 8'h00);
        #1;
        chk("cs0_bus", sysbus, 8'h00);
        chk("cs0_hit", {7'b0, bus.hit}, 8'h00);
        bus_idle();

        // DISP write/readback; SW_DATA ignores writes
        wr(5'd30, 8'hA5);
        chk("disp_a5", disp, 8'hA5);
        peek("disp_rd", 5'd30, 8'hA5);
        wr(5'd28, 8'h5A);
        peek("swdata_ro", 5'd28, 8'h00);

        // Bouncing input never accepted
        for (int seg = 0; seg < 20; seg++) begin
            switches = (seg % 2 == 0) ? 8'h01 : 8'h00;
            for (int c = 0; c < 5; c++) tick();
            peek("bounce_sw", 5'd28, 8'h00);
            peek("bounce_st", 5'd29, 8'h00);
        end

        // Clean change lands exactly 2+DB edges later
        switches = 8'h3C;
        for (int c = 0; c < DB + 1; c++) tick();
        peek("lat_before", 5'd28, 8'h00);
        tick();
        peek("lat_at", 5'd28, 8'h3C);
        peek("chg_set", 5'd29, 8'h01);
        set_bus(1'b1, 1'b1, 5'd29, 8'h00);
        #1;
        chk("status_rc", sysbus, 8'h01);
        tick();
        bus_idle();
        peek("status_clr", 5'd29, 8'h00);

        // Interrupt follows chg && ien; W1C drops both
        wr(5'd31, 8'hFF);
        peek("ctrl_rd", 5'd31, 8'h01);
        switches = 8'hC3;
        for (int c = 0; c < DB + 4; c++) tick();
        chk("irq_hi", {7'b0, irq}, 8'h01);
        peek("irq_status", 5'd29, 8'h01);
        wr(5'd29, 8'h01);
        chk("irq_lo", {7'b0, irq}, 8'h00);
        peek("w1c_status", 5'd29, 8'h00);

        // Acceptance coinciding with a STATUS read: set wins
        switches = 8'h5A;
        for (int c = 0; c < DB + 1; c++) tick();
        set_bus(1'b1, 1'b1, 5'd29, 8'h00);
        #1;
        chk("race_rd", sysbus, 8'h00);
        tick();
        bus_idle();
        peek("race_chg", 5'd29, 8'h01);
        chk("race_irq", {7'b0, irq}, 8'h01);

        // Reset mid-count with a write pending
        wr(5'd30, 8'hFF);
        switches = 8'h11;
        for (int c = 0; c < 8; c++) tick();
        reset = 1'b1;
        set_bus(1'b1, 1'b0, 5'd30, 8'h55);
        tick();
        reset = 1'b0;
        bus_idle();
        chk("rst_disp", disp, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            a = 5'd28 + 5'(i);
            peek("rst2_reg", a, 8'h00);
        end
        for (int c = 0; c < DB + 1; c++) tick();
        peek("restart_before", 5'd28, 8'h00);
        tick();
        peek("restart_at", 5'd28, 8'h11);

        // Outside the window: no hit, no drive, no state change
        wr(5'd30, 8'hFF);
        set_bus(1'b1, 1'b1, 5'd5, 8'h00);
        #1;
        chk("oow5_hit", {7'b0, bus.hit}, 8'h00);
        chk("oow5_bus", sysbus, 8'h00);
        set_bus(1'b1, 1'b1, 5'd6, 8'h00);
        #1;
        chk("oow6_bus", sysbus, 8'h00);
        set_bus(1'b1, 1'b0, 5'd6, 8'h77);
        tick();
        bus_idle();
        chk("oow_disp", disp, 8'hFF);

        // Randomized traffic against the model
        hold = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 2))
                    0:       switches = 8'h00;
                    1:       switches = 8'h0F;
                    default: switches = 8'($urandom);
                endcase
                hold = $urandom_range(1, 24);
            end
            hold--;
            op = $urandom_range(0, 3);
            a  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd28 + 5'($urandom_range(0, 3));
            set_bus(op != 0, op != 2, a, 8'($urandom));
            #1;
            exp_v = (m_hit(bus.CS, a) && bus.R_NW) ? m_read(a[1:0]) : tb_dat;
            chk("rnd_bus", sysbus, exp_v);
            chk("rnd_hit", {7'b0, bus.hit}, {7'b0, m_hit(bus.CS, a)});
            tick();
        end
        bus_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
